div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the EX stage. It is the requester side of the pipeline hold interface: its hold_req_o drives the pipeline controller's hold input, freezing the pipeline while a division runs.
- Returns the result plus a write-back address for one cycle when done.

---
 rtl/div_unit_pkg.sv | 29 ++
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M divider: operation select and FSM states.
package div_unit_pkg;

  localparam int unsigned DivDataW  = 32;
  localparam int unsigned RegAddrW  = 5;

  typedef enum logic [1:0] {
    OpDiv  = 2'd0,
    OpDivu = 2'd1,
    OpRem  = 2'd2,
    OpRemu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // DIV and REM are the signed ops; bit 1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with pipeline hold request.
// Define DIV_ZERO_FAST_EN to finish zero-divisor ops in one cycle instead of DATA_W.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              div_req_i,
  input  logic [1:0]        div_op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              abort_i,
  output logic              hold_req_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o
);

  div_state_e        state_q, state_d;
  logic [1:0]        op_q;
  logic [4:0]        waddr_q;
  logic [DATA_W-1:0] dvd_q;     // dividend magnitude, becomes the quotient as bits shift in
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              req_signed;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              accept;
  logic              zero_fast;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   trial;
  logic              qbit;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] result_calc;

  assign req_signed = op_is_signed(div_op_i);
  assign a_mag = (req_signed && dividend_i[DATA_W-1]) ? ('0 - dividend_i) : dividend_i;
  assign b_mag = (req_signed && divisor_i[DATA_W-1])  ? ('0 - divisor_i)  : divisor_i;
  assign accept = (state_q == StIdle) && div_req_i && !abort_i;

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (divisor_i == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // One restoring step: the trial subtract is DATA_W+1 bits wide so its MSB is the borrow.
  assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign qbit      = ~trial[DATA_W];

  // A zero divisor leaves the all-ones quotient unsigned.
  assign quo_fix     = (neg_quo_q && (dvs_q != '0)) ? ('0 - dvd_q) : dvd_q;
  assign rem_fix     = neg_rem_q ? ('0 - rem_q) : rem_q;
  assign result_calc = op_is_rem(op_q) ? rem_fix : quo_fix;

  always_comb begin
    state_d    = state_q;
    hold_req_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (div_req_i) begin
          hold_req_o = 1'b1;
          state_d    = zero_fast ? StDone : StCalc;
        end
      end
      StCalc: begin
        hold_req_o = 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d    = StIdle;
      hold_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      waddr_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= div_op_i;
        waddr_q   <= reg_waddr_i;
        dvs_q     <= b_mag;
        cnt_q     <= '0;
        neg_quo_q <= req_signed && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
        neg_rem_q <= req_signed && dividend_i[DATA_W-1];
        if (zero_fast) begin
          dvd_q <= '1;
          rem_q <= a_mag;
        end else begin
          dvd_q <= a_mag;
          rem_q <= '0;
        end
      end else if ((state_q == StCalc) && !abort_i) begin
        dvd_q <= {dvd_q[DATA_W-2:0], qbit};
        rem_q <= qbit ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
        cnt_q <= cnt_q + 1'b1;
      end else if ((state_q == StDone) && !abort_i) begin
        result_q <= result_calc;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign ready_o     = (state_q == StDone) && !abort_i;
  assign reg_we_o    = ready_o;
  assign result_o    = (state_q == StDone) ? result_calc : result_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, hold window, abort and reset.
module tb_div_unit;

  logic        clk_100MHz;
  logic        arst_n;
  logic        div_req_i;
  logic [1:0]  div_op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        abort_i;
  logic        hold_req_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZeroLat  = 1;
  localparam int ZeroHold = 1;
`else
  localparam int ZeroLat  = 33;
  localparam int ZeroHold = 33;
`endif

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_100MHz  (clk_100MHz),
    .arst_n      (arst_n),
    .div_req_i   (div_req_i),
    .div_op_i    (div_op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .abort_i     (abort_i),
    .hold_req_o  (hold_req_o),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Issues one request at a negedge and watches until ready_o (bounded), reporting
  // latency in cycles after the request cycle and the number of cycles hold_req_o was high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, output logic [31:0] res, output int lat,
                        output int holds, output logic [4:0] wa_out, output logic we,
                        output bit done);
    @(negedge clk_100MHz);
    div_req_i   = 1'b1;
    div_op_i    = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    #1;
    holds  = hold_req_o ? 1 : 0;
    lat    = 0;
    done   = 1'b0;
    res    = '0;
    wa_out = '0;
    we     = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_100MHz);
      div_req_i = 1'b0;
      #1;
      if (ready_o) begin
        lat    = i;
        res    = result_o;
        wa_out = reg_waddr_o;
        we     = reg_we_o;
        done   = 1'b1;
        break;
      end
      if (hold_req_o) holds++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d a=%h b=%h: ready_o never seen in 40 cycles", op, a, b);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    div_req_i = 1'b0; div_op_i = '0; dividend_i = '0; divisor_i = '0;
    reg_waddr_i = '0; abort_i = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    checks++;
    if ({busy_o, ready_o, reg_we_o, hold_req_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {busy_o, ready_o, reg_we_o, hold_req_o});
    end
    checks++;
    if (result_o !== 32'h0 || reg_waddr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_data got result=%h waddr=%0d want 0/0", result_o, reg_waddr_o);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_divu();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    run_op(2'd1, 32'd100, 32'd7, 5'd3, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'd14) begin errors++; $display("FAIL divu_res got %h want %h", res, 32'd14); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
    checks++;
    if (holds !== 33) begin errors++; $display("FAIL divu_hold got %0d want 33", holds); end
    checks++;
    if (we !== 1'b1 || wa !== 5'd3) begin
      errors++;
      $display("FAIL divu_wb got we=%b waddr=%0d want 1/3", we, wa);
    end
    @(negedge clk_100MHz);
    checks++;
    if (result_o !== 32'd14 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL divu_hold_result got %h ready=%b want %h ready=0", result_o, ready_o, 32'd14);
    end
    run_op(2'd3, 32'd100, 32'd7, 5'd4, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'd2) begin errors++; $display("FAIL remu_res got %h want %h", res, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    logic [1:0]  ops [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] av  [4] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'd7, 32'd7};
    logic [31:0] bv  [4] = '{32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] ev  [4] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], 5'(i + 8), res, lat, holds, wa, we, done);
      checks++;
      if (res !== ev[i]) begin
        errors++;
        $display("FAIL signed_%0d got %h want %h", i, res, ev[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd5, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'h80000000) begin
      errors++;
      $display("FAIL ovf_div got %h want %h", res, 32'h80000000);
    end
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd5, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL ovf_rem got %h want 0", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    run_op(2'd1, 32'd5, 32'd0, 5'd6, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu_zero got %h want ffffffff", res);
    end
    checks++;
    if (lat !== ZeroLat) begin
      errors++;
      $display("FAIL zero_latency got %0d want %0d", lat, ZeroLat);
    end
    checks++;
    if (holds !== ZeroHold) begin
      errors++;
      $display("FAIL zero_hold got %0d want %0d", holds, ZeroHold);
    end
    run_op(2'd2, 32'hFFFFFFFB, 32'd0, 5'd7, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL rem_zero got %h want fffffffb", res);
    end
    run_op(2'd0, 32'hFFFFFFF9, 32'd0, 5'd7, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_neg_zero got %h want ffffffff", res);
    end
  endtask

  task automatic test_abort();
    int readies = 0;
    @(negedge clk_100MHz);
    div_req_i = 1'b1; div_op_i = 2'd1; dividend_i = 32'd1000; divisor_i = 32'd3;
    reg_waddr_i = 5'd9;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_100MHz);
      div_req_i = 1'b0;
    end
    abort_i = 1'b1;
    #1;
    checks++;
    if (hold_req_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_same_cycle got hold=%b ready=%b want 0/0", hold_req_o, ready_o);
    end
    @(negedge clk_100MHz);
    abort_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, hold_req_o} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle got busy=%b hold=%b want 0/0", busy_o, hold_req_o);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_100MHz);
      if (ready_o) readies++;
    end
    checks++;
    if (readies !== 0) begin errors++; $display("FAIL abort_no_ready got %0d want 0", readies); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    @(negedge clk_100MHz);
    div_req_i = 1'b1; div_op_i = 2'd1; dividend_i = 32'd77; divisor_i = 32'd5;
    reg_waddr_i = 5'd12;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_100MHz);
      div_req_i = 1'b0;
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, ready_o, reg_we_o, hold_req_o} !== 4'b0000 || result_o !== 32'h0 ||
        reg_waddr_o !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b result=%h waddr=%0d want 0", 
               {busy_o, ready_o, reg_we_o, hold_req_o}, result_o, reg_waddr_o);
    end
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    run_op(2'd1, 32'd9, 32'd3, 5'd13, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'd3 || lat !== 33) begin
      errors++;
      $display("FAIL after_reset got %h lat %0d want 3 lat 33", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] wa; logic we; int lat, holds; bit done;
    run_op(2'd1, 32'd50, 32'd6, 5'd20, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'd8 || wa !== 5'd20) begin
      errors++;
      $display("FAIL b2b_first got %h waddr %0d want 8 waddr 20", res, wa);
    end
    // Next run_op drives the request in the cycle right after DONE.
    run_op(2'd3, 32'd50, 32'd6, 5'd21, res, lat, holds, wa, we, done);
    checks++;
    if (res !== 32'd2 || wa !== 5'd21 || lat !== 33) begin
      errors++;
      $display("FAIL b2b_second got %h waddr %0d lat %0d want 2 waddr 21 lat 33", res, wa, lat);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_div_zero();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
